// File: rtl/worksheet2_alu.sv
// worksheet2_alu: 8-bit button-selected ALU for the worksheet-2 board.
// - led/op_valid are purely combinational in a, b and the five buttons.
// - hold is a registered copy of the last valid result (synchronous,
//   active-high reset).
// - Optional build macro WS2_ALU_FLAGS_EN adds registered carry/zero/ovf
//   flags, captured under the same condition as hold.
// Button priority: btnU (ADD) > btnL (SUB) > btnC (AND) > btnR (OR) > btnD (XOR).

`default_nettype none

module worksheet2_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnC,
  input  logic       btnR,
  input  logic       btnD,
  output logic [7:0] led,
  output logic       op_valid,
  output logic [7:0] hold
`ifdef WS2_ALU_FLAGS_EN
  ,
  output logic       carry,
  output logic       zero,
  output logic       ovf
`endif
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5
  } op_e;

  op_e        op_s;
  logic [7:0] result_s;

  // Signed overflow of x + y: operands share a sign that the result lacks.
  function automatic logic add_ovf(input logic [7:0] x, input logic [7:0] y,
                                   input logic [7:0] r);
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // Signed overflow of x - y: operands differ in sign and result flips from x.
  function automatic logic sub_ovf(input logic [7:0] x, input logic [7:0] y,
                                   input logic [7:0] r);
    return (x[7] != y[7]) && (r[7] != x[7]);
  endfunction

  // Fixed-priority decode of the pushbuttons into a single operation.
  always_comb begin
    op_s = OP_NONE;
    if (btnU) begin
      op_s = OP_ADD;
    end else if (btnL) begin
      op_s = OP_SUB;
    end else if (btnC) begin
      op_s = OP_AND;
    end else if (btnR) begin
      op_s = OP_OR;
    end else if (btnD) begin
      op_s = OP_XOR;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Datapath: compute the 8-bit result of the selected operation.
  always_comb begin
    result_s = 8'h00;
    case (op_s)
      OP_ADD:  result_s = a + b;
      OP_SUB:  result_s = a + (~b) + 8'd1;
      OP_AND:  result_s = a & b;
      OP_OR:   result_s = a | b;
      OP_XOR:  result_s = a ^ b;
      OP_NONE: result_s = 8'h00;
      default: result_s = 8'h00;
    endcase
  end

  // Drive the combinational outputs straight from decode and datapath.
  always_comb begin
    led      = result_s;
    op_valid = (op_s != OP_NONE);
  end

  // Capture the last valid result; reset takes precedence over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= 8'h00;
    end else if (op_valid) begin
      hold <= result_s;
    end else begin
      hold <= hold;
    end
  end

`ifdef WS2_ALU_FLAGS_EN
  logic [8:0] add_wide_s;
  logic [8:0] sub_wide_s;
  logic       carry_s;
  logic       ovf_s;
  logic       zero_s;

  // Nine-bit sums expose the add carry and the subtract no-borrow bit.
  always_comb begin
    add_wide_s = {1'b0, a} + {1'b0, b};
    sub_wide_s = {1'b0, a} + {1'b0, ~b} + 9'd1;
  end

  // Flag values for the current operation; logic ops clear carry and ovf.
  always_comb begin
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    zero_s  = (result_s == 8'h00);
    case (op_s)
      OP_ADD: begin
        carry_s = add_wide_s[8];
        ovf_s   = add_ovf(a, b, result_s);
      end
      OP_SUB: begin
        carry_s = sub_wide_s[8];
        ovf_s   = sub_ovf(a, b, result_s);
      end
      OP_AND, OP_OR, OP_XOR, OP_NONE: begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
      default: begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Flags follow exactly the same capture rule as hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (op_valid) begin
      carry <= carry_s;
      zero  <= zero_s;
      ovf   <= ovf_s;
    end else begin
      carry <= carry;
      zero  <= zero;
      ovf   <= ovf;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_worksheet2_alu.sv
// Scoreboard bench for worksheet2_alu: a stimulus process applies directed
// and random vectors and queues the expected outputs computed by a plain
// arithmetic reference model; a monitor on the falling edge pops and compares.

module tb_worksheet2_alu;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] btn_v;   // {U, L, C, R, D}
  logic [7:0] led;
  logic       op_valid;
  logic [7:0] hold;
`ifdef WS2_ALU_FLAGS_EN
  logic       carry;
  logic       zero;
  logic       ovf;
`endif

  worksheet2_alu dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .btnU     (btn_v[4]),
    .btnL     (btn_v[3]),
    .btnC     (btn_v[2]),
    .btnR     (btn_v[1]),
    .btnD     (btn_v[0]),
    .led      (led),
    .op_valid (op_valid),
    .hold     (hold)
`ifdef WS2_ALU_FLAGS_EN
    ,
    .carry    (carry),
    .zero     (zero),
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic       valid;
    logic       hold_known;
    logic [7:0] hold;
    logic       c;
    logic       z;
    logic       o;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [4:0] btn;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Reference model from the arithmetic definitions, using plain integers.
  function automatic void model(input logic [4:0] btn, input int ai, input int bi,
                                output int res, output bit vld,
                                output bit cy, output bit ov);
    int sa;
    int sb;
    sa  = (ai > 127) ? ai - 256 : ai;
    sb  = (bi > 127) ? bi - 256 : bi;
    res = 0; vld = 1'b1; cy = 1'b0; ov = 1'b0;
    if (btn[4]) begin
      res = (ai + bi) % 256;
      cy  = (ai + bi) > 255;
      ov  = ((sa + sb) > 127) || ((sa + sb) < -128);
    end else if (btn[3]) begin
      res = (ai - bi + 256) % 256;
      cy  = (ai >= bi);
      ov  = ((sa - sb) > 127) || ((sa - sb) < -128);
    end else if (btn[2]) begin
      res = ai & bi;
    end else if (btn[1]) begin
      res = ai | bi;
    end else if (btn[0]) begin
      res = ai ^ bi;
    end else begin
      vld = 1'b0;
    end
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [5];
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFF;
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return 8'($urandom_range(255));
  endfunction

  // Stimulus: apply one vector per cycle and queue the expected outputs.
  initial begin
    vec_t       dir[$];
    vec_t       prev;
    vec_t       cur;
    int         m_hold = 0;
    bit         m_known = 1'b0;
    bit         mc = 1'b0, mz = 1'b0, mo = 1'b0;
    int         res;
    bit         vld, cy, ov;
    exp_t       e;
    logic [4:0] oh;

    reset = 1'b0; a = 8'h00; b = 8'h00; btn_v = 5'b00000;
    prev  = '{rst: 1'b0, btn: 5'b00000, a: 8'h00, b: 8'h00};

    dir.push_back('{1'b1, 5'b00000, 8'h00, 8'h00});
    dir.push_back('{1'b0, 5'b10000, 8'h0F, 8'h01});  // 0F+01 = 10
    dir.push_back('{1'b0, 5'b00000, 8'h12, 8'h34});  // idle, hold stays 10
    dir.push_back('{1'b0, 5'b01000, 8'h00, 8'h01});  // 00-01 = FF
    dir.push_back('{1'b0, 5'b10000, 8'hFF, 8'h01});  // FF+01 = 00
    dir.push_back('{1'b0, 5'b00100, 8'hF0, 8'h3C});  // AND = 30
    dir.push_back('{1'b0, 5'b00010, 8'hF0, 8'h3C});  // OR  = FC
    dir.push_back('{1'b0, 5'b00001, 8'hF0, 8'h3C});  // XOR = CC
    dir.push_back('{1'b0, 5'b10001, 8'h05, 8'h03});  // priority: 08
    dir.push_back('{1'b0, 5'b00000, 8'h05, 8'h03});  // none: led 00
    dir.push_back('{1'b0, 5'b01000, 8'h5A, 8'h5A});  // equal SUB = 00
    dir.push_back('{1'b1, 5'b10000, 8'h05, 8'h03});  // reset wins over capture
    dir.push_back('{1'b0, 5'b10000, 8'h05, 8'h03});
    dir.push_back('{1'b0, 5'b10000, 8'h7F, 8'h01});  // 80, ovf
    dir.push_back('{1'b0, 5'b01000, 8'h80, 8'h01});  // 7F, ovf
    dir.push_back('{1'b0, 5'b00000, 8'h00, 8'h00});
    for (int i = 0; i < 300; i++) begin
      cur.rst = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0: cur.btn = 5'b00000;
        1: begin oh = 5'b00001; cur.btn = oh << $urandom_range(4); end
        default: cur.btn = 5'($urandom_range(31));
      endcase
      cur.a = pick_operand();
      cur.b = pick_operand();
      dir.push_back(cur);
    end

    foreach (dir[i]) begin
      @(posedge clk);
      #2;
      // Account for the edge that just sampled the previous vector.
      model(prev.btn, int'(prev.a), int'(prev.b), res, vld, cy, ov);
      if (prev.rst) begin
        m_hold = 0; mc = 1'b0; mz = 1'b0; mo = 1'b0; m_known = 1'b1;
      end else if (vld) begin
        m_hold = res; mc = cy; mz = (res == 0); mo = ov; m_known = 1'b1;
      end
      cur   = dir[i];
      reset = cur.rst; btn_v = cur.btn; a = cur.a; b = cur.b;
      model(cur.btn, int'(cur.a), int'(cur.b), res, vld, cy, ov);
      e.led = 8'(res); e.valid = vld; e.hold_known = m_known;
      e.hold = 8'(m_hold); e.c = mc; e.z = mz; e.o = mo;
      exp_q.push_back(e);
      prev = cur;
    end
    stim_done = 1'b1;
  end

  // Monitor: between edges, pop one expectation and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led", int'(led), int'(e.led));
        check("op_valid", int'(op_valid), int'(e.valid));
        if (e.hold_known) begin
          check("hold", int'(hold), int'(e.hold));
`ifdef WS2_ALU_FLAGS_EN
          check("carry", int'(carry), int'(e.c));
          check("zero", int'(zero), int'(e.z));
          check("ovf", int'(ovf), int'(e.o));
`endif
        end
      end
    end
  end

  // Completion: wait for stimulus, drain the queue within a bound, summarise.
  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: stim_done=%0d queued=%0d, expected 1 and 0",
               stim_done, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
